// File: rtl/score_keeper.sv
// Game-control stage: turns hit/miss pulses into a BCD score with a combo multiplier,
// a lives counter and a BCD high score, and gates the rest of the game via game_in_progress.
module score_keeper #(
  parameter int SCORE_DIGITS = 4,
  parameter int START_LIVES  = 3,
  parameter int COMBO_MAX    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      miss,
  input  logic                      non_full_clear_hit,
  input  logic                      full_clear_hit,
  output logic                      game_in_progress,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] high_score_bcd,
  output logic [3:0]                lives,
  output logic [2:0]                combo,
  output logic                      new_high_score,
  output logic                      game_over
);

  localparam int W = 4 * SCORE_DIGITS;

  typedef enum logic [1:0] {IDLE, PLAYING, DRAIN} state_t;

  state_t        state, state_next;
  logic [W-1:0]  score_next, high_next;
  logic [5:0]    pending, pending_next;
  logic [7:0]    pending_sum;
  logic [4:0]    points;
  logic [3:0]    lives_next;
  logic [2:0]    combo_next;
  logic          nhs_next, game_over_next;

  // BCD +1 with ripple carry; an all-nines value comes back unchanged (saturation).
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) r = v;
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_next     = state;
    score_next     = score_bcd;
    high_next      = high_score_bcd;
    lives_next     = lives;
    combo_next     = combo;
    nhs_next       = new_high_score;
    game_over_next = 1'b0;
    points         = '0;
    pending_sum    = {2'b00, pending};

    // Pending points drain into the score one per cycle regardless of state.
    if (pending != 6'd0) begin
      pending_sum = {2'b00, pending} - 8'd1;
      score_next  = bcd_inc(score_bcd);
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_next  = PLAYING;
          score_next  = '0;
          pending_sum = '0;
          lives_next  = 4'(START_LIVES);
          combo_next  = 3'd1;
          nhs_next    = 1'b0;
        end
      end
      PLAYING: begin
        // Points use the pre-update combo; a full clear wins over a partial hit.
        if (full_clear_hit)          points = {1'b0, combo, 1'b0};
        else if (non_full_clear_hit) points = {2'b00, combo};
        pending_sum = pending_sum + {3'b000, points};

        if (miss) begin
          combo_next = 3'd1;
          lives_next = (lives == 4'd0) ? 4'd0 : lives - 4'd1;
          if (lives <= 4'd1) state_next = DRAIN;
        end else if (full_clear_hit) begin
          combo_next = (combo >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : combo + 3'd1;
        end
      end
      DRAIN: begin
        if (pending == 6'd0) begin
          // Digits are 0..9, so a plain unsigned compare is the MSD-first digit compare.
          if (score_bcd > high_score_bcd) begin
            high_next = score_bcd;
            nhs_next  = 1'b1;
          end
          game_over_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    pending_next = (pending_sum > 8'd63) ? 6'd63 : pending_sum[5:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      score_bcd        <= '0;
      high_score_bcd   <= '0;
      pending          <= '0;
      lives            <= '0;
      combo            <= 3'd1;
      game_in_progress <= 1'b0;
      new_high_score   <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      state            <= state_next;
      score_bcd        <= score_next;
      high_score_bcd   <= high_next;
      pending          <= pending_next;
      lives            <= lives_next;
      combo            <= combo_next;
      game_in_progress <= (state_next == PLAYING);
      new_high_score   <= nhs_next;
      game_over        <= game_over_next;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a 4-digit instance for game flow and a
// 1-digit instance for score saturation.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, miss, nfch, fch;
  logic        gip, nhs, go;
  logic [15:0] score, hs;
  logic [3:0]  lives;
  logic [2:0]  combo;

  logic        s_start, s_miss, s_nfch, s_fch;
  logic        s_gip, s_nhs, s_go;
  logic [3:0]  s_score, s_hs, s_lives;
  logic [2:0]  s_combo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .reset(reset), .start(start), .miss(miss),
    .non_full_clear_hit(nfch), .full_clear_hit(fch),
    .game_in_progress(gip), .score_bcd(score), .high_score_bcd(hs),
    .lives(lives), .combo(combo), .new_high_score(nhs), .game_over(go)
  );

  score_keeper #(.SCORE_DIGITS(1)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .miss(s_miss),
    .non_full_clear_hit(s_nfch), .full_clear_hit(s_fch),
    .game_in_progress(s_gip), .score_bcd(s_score), .high_score_bcd(s_hs),
    .lives(s_lives), .combo(s_combo), .new_high_score(s_nhs), .game_over(s_go)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic m, input logic n, input logic f);
    miss = m; nfch = n; fch = f;
    tick();
    miss = 1'b0; nfch = 1'b0; fch = 1'b0;
  endtask

  task automatic s_pulse(input logic m, input logic n, input logic f);
    s_miss = m; s_nfch = n; s_fch = f;
    tick();
    s_miss = 1'b0; s_nfch = 1'b0; s_fch = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {start, miss, nfch, fch} = '0;
    {s_start, s_miss, s_nfch, s_fch} = '0;
    wait_cycles(2);
    check("rst_gip",   gip,   0);
    check("rst_score", score, 16'h0000);
    check("rst_hs",    hs,    16'h0000);
    check("rst_lives", lives, 0);
    check("rst_combo", combo, 1);
    check("rst_nhs",   nhs,   0);
    check("rst_go",    go,    0);
    reset = 1'b0;
    tick();

    // Game 1
    do_start();
    check("g1_gip",   gip,   1);
    check("g1_lives", lives, 3);
    check("g1_combo", combo, 1);
    check("g1_score", score, 16'h0000);

    pulse(0, 0, 1);
    check("fc1_combo", combo, 2);
    tick();
    check("fc1_first_inc", score, 16'h0001);
    wait_cycles(8);
    check("fc1_score", score, 16'h0002);

    pulse(0, 0, 1);
    check("fc2_combo", combo, 3);
    wait_cycles(9);
    check("fc2_score", score, 16'h0006);

    pulse(0, 0, 1);
    check("fc3_combo", combo, 4);
    wait_cycles(9);
    check("fc3_score", score, 16'h0012);

    pulse(0, 0, 1);
    check("fc4_combo_cap", combo, 4);
    wait_cycles(9);
    check("fc4_score", score, 16'h0020);

    // miss+full with combo 4: +8, combo back to 1
    pulse(1, 0, 1);
    check("mf1_combo", combo, 1);
    check("mf1_lives", lives, 2);
    check("mf1_gip",   gip,   1);
    wait_cycles(9);
    check("mf1_score", score, 16'h0028);

    pulse(0, 0, 1);
    wait_cycles(9);
    check("fc5_score", score, 16'h0030);
    pulse(0, 0, 1);
    check("fc6_combo", combo, 3);
    wait_cycles(9);
    check("fc6_score", score, 16'h0034);

    pulse(0, 1, 0);
    check("nf_combo", combo, 3);
    wait_cycles(9);
    check("nf_score", score, 16'h0037);

    pulse(1, 0, 1);
    check("mf2_combo", combo, 1);
    check("mf2_lives", lives, 1);
    wait_cycles(9);
    check("mf2_score", score, 16'h0043);

    // Fatal miss with pending already 0: game_over two edges later
    pulse(1, 0, 0);
    check("fatal_gip",   gip,   0);
    check("fatal_lives", lives, 0);
    check("fatal_go0",   go,    0);
    start = 1'b1;  // ignored in DRAIN
    tick();
    start = 1'b0;
    check("g1_go",  go,  1);
    check("g1_hs",  hs,  16'h0043);
    check("g1_nhs", nhs, 1);
    check("g1_gip_after", gip, 0);
    tick();
    check("g1_go_once", go, 0);

    // Game 2: lower score, back-to-back miss+partial hits
    do_start();
    check("g2_nhs_clr", nhs,   0);
    check("g2_score",   score, 16'h0000);
    check("g2_hs_kept", hs,    16'h0043);
    pulse(1, 1, 0);
    pulse(1, 1, 0);
    check("g2_lives1", lives, 1);
    check("g2_score1", score, 16'h0001);
    pulse(1, 1, 0);
    check("g2_gip",   gip,   0);
    check("g2_score2", score, 16'h0002);
    tick();
    check("g2_score3", score, 16'h0003);
    check("g2_go0",    go,    0);
    tick();
    check("g2_go",  go,  1);
    check("g2_hs",  hs,  16'h0043);
    check("g2_nhs", nhs, 0);
    tick();

    // Game 3: reset while draining
    do_start();
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 1);
    check("g3_drain_gip", gip, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r2_score", score, 16'h0000);
    check("r2_hs",    hs,    16'h0000);
    check("r2_lives", lives, 0);
    check("r2_combo", combo, 1);
    check("r2_gip",   gip,   0);
    check("r2_go",    go,    0);
    check("r2_nhs",   nhs,   0);
    wait_cycles(3);
    check("r2_hold_score", score, 16'h0000);

    // One-digit instance: 2+4+6 = 12 points must saturate at 9
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_pulse(0, 0, 1);
    s_pulse(0, 0, 1);
    s_pulse(0, 0, 1);
    check("s_score_early", s_score, 2);
    check("s_combo",       s_combo, 4);
    wait_cycles(20);
    check("s_score_sat", s_score, 9);
    s_pulse(1, 0, 0);
    s_pulse(1, 0, 0);
    s_pulse(1, 0, 0);
    check("s_gip", s_gip, 0);
    tick();
    check("s_go",  s_go,  1);
    check("s_hs",  s_hs,  9);
    check("s_nhs", s_nhs, 1);
    check("s_score_final", s_score, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
